// File: rtl/snake_move_ctrl_if.sv
// Handshake bundle between the game logic / VGA renderer and snake_move_ctrl.
interface snake_move_ctrl_if;
  logic        tick;
  logic [1:0]  dir;
  logic        dir_valid;
  logic        grow;
  logic        restart;
  logic        query_valid;
  logic [12:0] query_cell;
  logic        query_hit;
  logic        query_hit_valid;
  logic [12:0] head_cell;
  logic [8:0]  length;
  logic        busy;
  logic        dead;
  logic        overrun;

  modport master (
    output tick, dir, dir_valid, grow, restart, query_valid, query_cell,
    input  query_hit, query_hit_valid, head_cell, length, busy, dead, overrun
  );
  modport slave (
    input  tick, dir, dir_valid, grow, restart, query_valid, query_cell,
    output query_hit, query_hit_valid, head_cell, length, busy, dead, overrun
  );
endinterface

// File: rtl/snake_move_ctrl.sv
// Snake body sequencer: occupancy bitmap, circular body queue, move FSM and
// render-query arbitration. Define SNAKE_WRAP_EN to wrap at the grid edges.
module snake_move_ctrl #(
  parameter int GRID_W   = 80,
  parameter int GRID_H   = 60,
  parameter int MAX_LEN  = 256,
  parameter int INIT_LEN = 3
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  snake_move_ctrl_if.slave bus
);
  localparam int CELLS = GRID_W * GRID_H;
  localparam int PW    = $clog2(MAX_LEN);
  localparam int XW    = $clog2(GRID_W);
  localparam int YW    = $clog2(GRID_H);
  localparam logic [12:0] HOME = 13'((GRID_H / 2) * GRID_W + GRID_W / 2);

  typedef enum logic [2:0] {INIT_CLR, SEED, IDLE, CHECK, WR_HEAD, CLR_TAIL, DEAD} state_t;

  state_t            state;
  logic [CELLS-1:0]  bitmap;
  logic [12:0]       queue [MAX_LEN];
  logic [12:0]       clr_idx, nxt, tail_r;
  logic [PW-1:0]     seed_idx, hd_ptr, tl_ptr;
  logic [XW-1:0]     hx, nx, nx_r;
  logic [YW-1:0]     hy, ny, ny_r;
  logic [1:0]        cur_dir, lat_dir;
  logic              grow_pend, wall, wall_kill, gnt, grow_eff;
  logic [12:0]       cell_c, seed_cell, q_idx, tail_cell;
  logic              bm_we, bm_wd, q_we;
  logic [12:0]       bm_addr;
  logic [PW-1:0]     q_addr;
  logic [12:0]       q_wd;

  // Render queries own the bitmap port; every bitmap-touching state waits.
  assign gnt       = !bus.query_valid;
  assign grow_eff  = grow_pend && (bus.length != 9'(MAX_LEN));
  assign seed_cell = HOME - 13'(seed_idx);
  assign tail_cell = queue[tl_ptr];
  assign q_idx     = (bus.query_cell < 13'(CELLS)) ? bus.query_cell : '0;
  assign bus.busy  = (state != IDLE) && (state != DEAD);

  always_comb begin
    nx   = hx;
    ny   = hy;
    wall = 1'b0;
    case (lat_dir)
      2'b11:   if (hy == '0) begin wall = 1'b1; ny = YW'(GRID_H - 1); end else ny = hy - YW'(1);
      2'b00:   if (hy == YW'(GRID_H - 1)) begin wall = 1'b1; ny = '0; end else ny = hy + YW'(1);
      2'b10:   if (hx == '0) begin wall = 1'b1; nx = XW'(GRID_W - 1); end else nx = hx - XW'(1);
      default: if (hx == XW'(GRID_W - 1)) begin wall = 1'b1; nx = '0; end else nx = hx + XW'(1);
    endcase
`ifdef SNAKE_WRAP_EN
    wall_kill = 1'b0;
`else
    wall_kill = wall;
`endif
    cell_c = 13'(ny) * 13'(GRID_W) + 13'(nx);
  end

  always_comb begin
    bm_we   = 1'b0;
    bm_addr = nxt;
    bm_wd   = 1'b1;
    q_we    = 1'b0;
    q_addr  = hd_ptr;
    q_wd    = nxt;
    if (gnt && !bus.restart) begin
      case (state)
        INIT_CLR: begin bm_we = 1'b1; bm_addr = clr_idx; bm_wd = 1'b0; end
        // Seed head-first; queue slots filled back to front so slot 0 is the tail.
        SEED: begin
          bm_we = 1'b1; bm_addr = seed_cell;
          q_we  = 1'b1; q_addr = PW'(INIT_LEN - 1) - seed_idx; q_wd = seed_cell;
        end
        WR_HEAD:  begin bm_we = 1'b1; q_we = 1'b1; end
        // Tail chase: the new head landed on the old tail, keep it set.
        CLR_TAIL: begin bm_we = (tail_r != nxt); bm_addr = tail_r; bm_wd = 1'b0; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iCLK) if (bm_we) bitmap[bm_addr] <= bm_wd;
  always_ff @(posedge iCLK) if (q_we) queue[q_addr] <= q_wd;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state               <= INIT_CLR;
      clr_idx             <= '0;
      seed_idx            <= '0;
      hd_ptr              <= '0;
      tl_ptr              <= '0;
      nxt                 <= HOME;
      tail_r              <= '0;
      hx                  <= XW'(GRID_W / 2);
      hy                  <= YW'(GRID_H / 2);
      nx_r                <= '0;
      ny_r                <= '0;
      cur_dir             <= 2'b01;
      lat_dir             <= 2'b01;
      grow_pend           <= 1'b0;
      bus.query_hit       <= 1'b0;
      bus.query_hit_valid <= 1'b0;
      bus.head_cell       <= HOME;
      bus.length          <= '0;
      bus.dead            <= 1'b0;
      bus.overrun         <= 1'b0;
    end else begin
      bus.query_hit_valid <= bus.query_valid;
      bus.query_hit       <= bus.query_valid && (bus.query_cell < 13'(CELLS)) && bitmap[q_idx];
      bus.overrun         <= bus.tick && bus.busy;
      if (bus.dir_valid && (bus.dir != ~cur_dir)) lat_dir <= bus.dir;
      case (state)
        INIT_CLR: if (gnt) begin
          if (clr_idx == 13'(CELLS - 1)) begin state <= SEED; seed_idx <= '0; end
          else clr_idx <= clr_idx + 13'd1;
        end
        SEED: if (gnt) begin
          if (seed_idx == PW'(INIT_LEN - 1)) begin
            state         <= IDLE;
            bus.length    <= 9'(INIT_LEN);
            hd_ptr        <= PW'(INIT_LEN);
            tl_ptr        <= '0;
            cur_dir       <= 2'b01;
            lat_dir       <= 2'b01;
            hx            <= XW'(GRID_W / 2);
            hy            <= YW'(GRID_H / 2);
            bus.head_cell <= HOME;
          end else seed_idx <= seed_idx + PW'(1);
        end
        IDLE: if (bus.tick) begin
          cur_dir <= lat_dir;
          if (wall_kill) begin state <= DEAD; bus.dead <= 1'b1; end
          else begin nxt <= cell_c; nx_r <= nx; ny_r <= ny; state <= CHECK; end
        end
        CHECK: if (gnt) begin
          // Tail is captured here: a full queue overwrites its slot in WR_HEAD.
          tail_r <= tail_cell;
          if (bitmap[nxt] && !((nxt == tail_cell) && !grow_eff)) begin
            state <= DEAD; bus.dead <= 1'b1;
          end else state <= WR_HEAD;
        end
        WR_HEAD: if (gnt) begin
          hd_ptr        <= hd_ptr + PW'(1);
          bus.head_cell <= nxt;
          hx            <= nx_r;
          hy            <= ny_r;
          grow_pend     <= 1'b0;
          if (grow_eff) begin bus.length <= bus.length + 9'd1; state <= IDLE; end
          else state <= CLR_TAIL;
        end
        CLR_TAIL: if (gnt) begin tl_ptr <= tl_ptr + PW'(1); state <= IDLE; end
        DEAD: ;
        default: state <= INIT_CLR;
      endcase
      if (bus.grow) grow_pend <= 1'b1;
      if (bus.restart) begin
        state      <= INIT_CLR;
        clr_idx    <= '0;
        hd_ptr     <= '0;
        tl_ptr     <= '0;
        grow_pend  <= 1'b0;
        bus.dead   <= 1'b0;
        bus.length <= '0;
      end
    end
  end
endmodule

// File: tb/tb_snake_move_ctrl.sv
// Randomized bench for snake_move_ctrl against a queue/array model of the game rules.
module tb_snake_move_ctrl;
  localparam int W = 80, H = 60, CELLS = W * H, MAXL = 256, HOME = 2440;

  logic iCLK = 1'b0, iRST_N = 1'b0;
  always #5 iCLK = ~iCLK;

  snake_move_ctrl_if bus();
  snake_move_ctrl dut (.iCLK(iCLK), .iRST_N(iRST_N), .bus(bus));

  int n_cmp = 0, n_bad = 0;
  bit occ [CELLS];
  int body [$];
  int m_cur, m_lat, restarts;
  bit m_grow, m_dead;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge iCLK); #1;
  endtask

  function automatic void m_init();
    foreach (occ[i]) occ[i] = 1'b0;
    body.delete();
    for (int i = 2; i >= 0; i--) begin body.push_back(HOME - i); occ[HOME - i] = 1'b1; end
    m_cur = 1; m_lat = 1; m_grow = 0; m_dead = 0;
  endfunction

  function automatic int m_head();
    return body[body.size() - 1];
  endfunction

  // Returns the cycle (tick = cycle 0) in which the FSM is back in IDLE or DEAD.
  function automatic int m_move();
    int x, y, nx, ny, c, t;
    bit g, wall;
    m_cur = m_lat;
    x = m_head() % W; y = m_head() / W; nx = x; ny = y;
    case (m_cur)
      3: ny = y - 1;
      0: ny = y + 1;
      2: nx = x - 1;
      default: nx = x + 1;
    endcase
    wall = (nx < 0) || (nx >= W) || (ny < 0) || (ny >= H);
`ifdef SNAKE_WRAP_EN
    nx = (nx + W) % W; ny = (ny + H) % H; wall = 0;
`endif
    if (wall) begin m_dead = 1; return 1; end
    c = ny * W + nx;
    g = m_grow && (body.size() < MAXL);
    if (occ[c] && !(c == body[0] && !g)) begin m_dead = 1; return 2; end
    body.push_back(c); occ[c] = 1'b1; m_grow = 0;
    if (g) return 3;
    t = body.pop_front();
    if (t != c) occ[t] = 1'b0;
    return 4;
  endfunction

  task automatic query(input int c, input string tag);
    bus.query_valid = 1'b1; bus.query_cell = 13'(c);
    step();
    chk(tag, 32'({bus.query_hit_valid, bus.query_hit}), 32'({1'b1, occ[c]}));
    bus.query_valid = 1'b0;
  endtask

  task automatic set_dir(input int d);
    bus.dir_valid = 1'b1; bus.dir = 2'(d);
    step();
    bus.dir_valid = 1'b0;
    if (d != (~m_cur & 3)) m_lat = d;
  endtask

  task automatic pulse_grow();
    bus.grow = 1'b1; step(); bus.grow = 1'b0; m_grow = 1;
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (bus.busy === 1'b1 && n < 6000) begin step(); n++; end
    chk(tag, 32'(n), 32'd4803);
    chk({tag, "_len"}, 32'(bus.length), 32'd3);
    chk({tag, "_head"}, 32'(bus.head_cell), 32'(HOME));
    chk({tag, "_dead"}, 32'(bus.dead), 32'd0);
  endtask

  task automatic restart();
    bus.restart = 1'b1; step(); bus.restart = 1'b0;
    m_init();
    // Queries stay answered during the clear and stall it by one cycle each.
    bus.query_valid = 1'b1; bus.query_cell = 13'($urandom_range(0, CELLS - 1));
    step(); chk("init_hv", 32'(bus.query_hit_valid), 32'd1);
    step(); chk("init_hv", 32'(bus.query_hit_valid), 32'd1);
    bus.query_valid = 1'b0;
    wait_init("restart_init");
  endtask

  task automatic do_move(input bit dbl, input int stall);
    int sc [16];
    bit se [16];
    int lat, cyc, exp_cyc;
    for (int i = 0; i < stall; i++) begin
      sc[i] = ($urandom_range(0, 1) == 1) ? body[$urandom_range(0, body.size() - 1)]
                                          : $urandom_range(0, CELLS - 1);
      se[i] = occ[sc[i]];
    end
    lat = m_move();
    bus.tick = 1'b1;
    step(); cyc = 1;
    chk("ovr_idle", 32'(bus.overrun), 32'd0);
    if (dbl) begin
      step(); cyc = 2;
      chk("ovr_pulse", 32'(bus.overrun), 32'(lat > 1));
    end
    bus.tick = 1'b0;
    if (stall > 0) begin
      bus.query_valid = 1'b1;
      for (int i = 0; i < stall; i++) begin
        bus.query_cell = 13'(sc[i]);
        step(); cyc++;
        chk("stall_q", 32'({bus.query_hit_valid, bus.query_hit}), 32'({1'b1, se[i]}));
      end
      bus.query_valid = 1'b0;
    end
    while (bus.busy === 1'b1 && cyc < 60) begin step(); cyc++; end
    exp_cyc = lat + stall;
    if (dbl && exp_cyc < 2) exp_cyc = 2;
    chk("move_lat", 32'(cyc), 32'(exp_cyc));
    chk("head", 32'(bus.head_cell), 32'(m_head()));
    chk("len", 32'(bus.length), 32'(body.size()));
    chk("dead", 32'(bus.dead), 32'(m_dead));
    chk("ovr_end", 32'(bus.overrun), 32'd0);
    query(m_head(), "q_head");
    query(body[0], "q_tail");
    query($urandom_range(0, CELLS - 1), "q_rand");
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.tick = 0; bus.dir = 2'b01; bus.dir_valid = 0; bus.grow = 0; bus.restart = 0;
    bus.query_valid = 0; bus.query_cell = '0;
    restarts = 0;
    step(); step();
    chk("rst_hit", 32'(bus.query_hit), 32'd0);
    chk("rst_hv", 32'(bus.query_hit_valid), 32'd0);
    chk("rst_head", 32'(bus.head_cell), 32'd2440);
    chk("rst_len", 32'(bus.length), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd1);
    chk("rst_dead", 32'(bus.dead), 32'd0);
    chk("rst_ovr", 32'(bus.overrun), 32'd0);
    iRST_N = 1'b1;
    m_init();
    wait_init("reset_init");
    query(2440, "seed_2440"); query(2439, "seed_2439");
    query(2438, "seed_2438"); query(2437, "seed_2437");
    step(); chk("hv_drop", 32'(bus.query_hit_valid), 32'd0);

    for (int i = 0; i < 3; i++) do_move(0, 0);
    chk("head_3moves", 32'(bus.head_cell), 32'd2443);
    query(2440, "vacated_2440"); query(2441, "body_2441");

    set_dir(2);
    pulse_grow();
    do_move(0, 0);
    chk("grow_len", 32'(bus.length), 32'd4);
    chk("grow_head", 32'(bus.head_cell), 32'd2444);
    do_move(0, 10);
    do_move(1, 0);

    while (m_head() % W != W - 1) do_move(0, 0);
    do_move(0, 0);
`ifdef SNAKE_WRAP_EN
    chk("wrap_head", 32'(bus.head_cell), 32'd2400);
`else
    chk("wall_dead", 32'(bus.dead), 32'd1);
    chk("wall_head", 32'(bus.head_cell), 32'd2479);
    bus.tick = 1'b1; step(); bus.tick = 1'b0;
    chk("dead_tick_ovr", 32'(bus.overrun), 32'd0);
    step();
    chk("dead_sticky", 32'(bus.dead), 32'd1);
`endif

    restart();
    pulse_grow(); do_move(0, 0);
    set_dir(3); do_move(0, 0);
    set_dir(2); do_move(0, 0);
    set_dir(0); do_move(0, 0);
    chk("chase_alive", 32'(bus.dead), 32'd0);
    query(2440, "chase_cell");
    set_dir(1); do_move(0, 0);
    chk("chase2_alive", 32'(bus.dead), 32'd0);
    chk("chase_len", 32'(bus.length), 32'd4);
    pulse_grow(); set_dir(3); do_move(0, 0);
    chk("chase_grow_dead", 32'(bus.dead), 32'd1);

    restart();
    for (int it = 0; it < 150; it++) begin
      bit dbl;
      int r, stall;
      if (m_dead) begin
        if (restarts >= 3) break;
        restarts++;
        restart();
      end
      r = $urandom_range(0, 99);
      if (r < 30) set_dir($urandom_range(0, 3));
      if (r >= 85) pulse_grow();
      dbl = ($urandom_range(0, 9) == 0);
      stall = (!dbl && $urandom_range(0, 7) == 0) ? $urandom_range(1, 5) : 0;
      do_move(dbl, stall);
    end

    for (int c = 0; c < CELLS; c++) query(c, "sweep");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
